fifo_rptr_empty: RTL
====================

Name: fifo_rptr_empty

Overview:
Read-side pointer and empty-flag stage of the async FIFO, in the read clock domain.
- Brings the write-domain Gray write pointer across with a 2-flop synchroniser.
- Maintains the binary and Gray read pointers and generates the registered empty flag.
- Passes the synchronised Gray write pointer downstream to the gray-to-binary converter for fill-level computation.

Parameters:
ADDR_SIZE, 4, FIFO address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits (extra wrap bit).

Ports:
rclk  in  1  read-domain clock, all flops on rising edge
rrst_n  in  1  asynchronous active-low reset, read domain
rinc  in  1  read request from consumer
wptr_gray  in  ADDR_SIZE+1  Gray write pointer, launched from write domain, asynchronous to rclk
raddr  out  ADDR_SIZE  RAM read address = rbin[ADDR_SIZE-1:0]
rptr_gray  out  ADDR_SIZE+1  registered Gray read pointer, sent to write-domain synchroniser
wq2_wptr_gray  out  ADDR_SIZE+1  synchronised Gray write pointer, to gray-to-binary converter
rempty  out  1  registered empty flag
rd_fire  out  1  combinational rinc & ~rempty; RAM read strobe / pointer advance
rd_underflow  out  1  one-cycle pulse: rinc seen while rempty
rd_underflow_sticky  out  1  set by any underflow, cleared only by reset

Behaviour:
- Reset values (async, on rrst_n low):
  - wq1 = 0, wq2_wptr_gray = 0
  - rbin = 0, rptr_gray = 0, raddr = 0
  - rempty = 1
  - rd_underflow = 0, rd_underflow_sticky = 0
- Reset release is synchronous to rclk.
- Synchroniser: wq1 <= wptr_gray; wq2_wptr_gray <= wq1.
  - No logic between the two stages.
  - wptr_gray is sampled only by wq1.
- Pointer update each rclk edge:
  - rbin_next = rbin + rd_fire, modulo 2**(ADDR_SIZE+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rbin <= rbin_next; rptr_gray <= rgray_next.
  - rptr_gray changes by at most one bit per cycle; this is mandatory for CDC safety.
- Empty flag:
  - rempty <= (rgray_next == wq2_wptr_gray).
  - It compares the next read pointer with the current synchronised write pointer, so reading the last word asserts rempty on the same edge that advances the pointer. No extra bubble.
- Latency:
  - A change on wptr_gray reaches wq2_wptr_gray after 2 rclk edges.
  - rempty deasserts on the 3rd rclk edge after the change.
  - A read advances raddr/rptr_gray 1 edge after the cycle in which rd_fire is high.
- Underflow:
  - rinc with rempty=1 gives rd_fire=0 and no pointer change.
  - rd_underflow = 1 for exactly the next cycle.
  - rd_underflow_sticky is set and holds.
- Wrap-around:
  - rbin 2**(ADDR_SIZE+1)-1 -> 0; Gray 10000 -> 00000 for ADDR_SIZE=4.
  - raddr 1111 -> 0000 at the midpoint, with the wrap bit toggling.
  - Empty detection is unaffected because both Gray pointers wrap identically.
- Simultaneous events:
  - Read of the last word in the same cycle wq2 advances: rempty uses the updated compare on the next edge. Evaluated as rgray_next vs current wq2; rempty may stay 1 one cycle extra and then clears.
  - Never a false "not empty".
- Pessimism: rempty is conservative; it may lag writes, it must never lag reads.
- Reset mid-operation: all state returns to reset values immediately, regardless of rinc.

Decomposition:
- Shared FIFO package:
  - ADDR_SIZE default constant
  - PTR_W = ADDR_SIZE+1
  - typedef ptr_t (logic [PTR_W-1:0])
  - function bin2gray
- One natural sub-module: sync_2ff, a parameterised-width 2-flop synchroniser with async active-low reset, reused by the write side for rptr_gray.

Test Plan:
1. Reset: rrst_n=0 mid-traffic with rinc=1 -> rempty=1, raddr=0, rptr_gray=0, wq2_wptr_gray=0, rd_underflow_sticky=0 within the same cycle.
2. Single write: wptr_gray 00000 -> 00001 -> rempty falls on the 3rd rclk edge. Then rinc=1 for 1 cycle -> raddr=1, rptr_gray=00001, rempty=1 on that edge.
3. Burst: wptr_gray stepped to Gray(16)=11000, 16 reads back-to-back -> raddr 0..15, rptr_gray sequence is valid Gray (1 bit change each), rempty=1 after the 16th read with no bubble.
4. Wrap: 32 write/read pairs -> rbin 31 -> 0, rptr_gray 10000 -> 00000, rempty tracks correctly across the wrap.
5. Underflow: rempty=1, rinc=1 for 2 cycles -> pointers unchanged, rd_underflow high 2 cycles, sticky=1 until reset.
6. Race: read of the last word in the same cycle wq1 gets a new wptr -> rempty asserts 1 cycle then deasserts; no read ever issues with rempty=1 (assertion: rd_fire -> !rempty).

Source files
------------

// File: rtl/fifo_rptr_empty_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type and the
// binary-to-Gray helper used by both pointer stages.
package fifo_rptr_empty_pkg;

   localparam int ADDR_SIZE_DEF = 4;
   localparam int PTR_W         = ADDR_SIZE_DEF + 1;

   typedef logic [PTR_W-1:0] ptr_t;

   // Width-agnostic so pointer stages of any ADDR_SIZE can share it.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin_v);
      return bin_v ^ (bin_v >> 1'b1);
   endfunction

endpackage

// File: rtl/fifo_rptr_empty_if.sv
// Read-side bundle between the consumer/write-domain pointer and the
// read-pointer/empty stage.
interface fifo_rptr_empty_if
   import fifo_rptr_empty_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
);

   logic                 rinc;
   logic [ADDR_SIZE:0]   wptr_gray;
   logic [ADDR_SIZE-1:0] raddr;
   logic [ADDR_SIZE:0]   rptr_gray;
   logic [ADDR_SIZE:0]   wq2_wptr_gray;
   logic                 rempty;
   logic                 rd_fire;
   logic                 rd_underflow;
   logic                 rd_underflow_sticky;

   modport master (
      output rinc, wptr_gray,
      input  raddr, rptr_gray, wq2_wptr_gray, rempty, rd_fire,
             rd_underflow, rd_underflow_sticky
   );

   modport slave (
      input  rinc, wptr_gray,
      output raddr, rptr_gray, wq2_wptr_gray, rempty, rd_fire,
             rd_underflow, rd_underflow_sticky
   );

endinterface

// File: rtl/fifo_rptr_empty_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer; the first stage is the only
// sampler of the asynchronous input and nothing sits between the stages.
module sync_2ff #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q1_q, q1_d;
   logic [WIDTH-1:0] q2_q, q2_d;

   // Pure wiring into the stages.
   always_comb begin
      q1_d = d_i;
      q2_d = q1_q;
   end

   // Synchroniser stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_q <= {WIDTH{1'b0}};
         q2_q <= {WIDTH{1'b0}};
      end else begin
         q1_q <= q1_d;
         q2_q <= q2_d;
      end
   end

   assign q_o = q2_q;

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer stage: synchronises the Gray write pointer, advances the
// binary/Gray read pointers and produces the registered empty flag.
module fifo_rptr_empty
   import fifo_rptr_empty_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic             rclk,
   input  logic             rrst_n,
   fifo_rptr_empty_if.slave bus
);

   localparam int RPTR_W = ADDR_SIZE + 1;

   logic [RPTR_W-1:0] wq2_s;
   logic [RPTR_W-1:0] rbin_q, rbin_d;
   logic [RPTR_W-1:0] rgray_q, rgray_d;
   logic              rempty_q, rempty_d;
   logic              underflow_q, underflow_d;
   logic              sticky_q, sticky_d;
   logic              rd_fire_s;

   sync_2ff #(.WIDTH(RPTR_W)) u_wptr_sync (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d_i   (bus.wptr_gray),
      .q_o   (wq2_s)
   );

   assign rd_fire_s = bus.rinc & ~rempty_q;

   // Empty compares the next read pointer so the last read flags empty with no bubble.
   always_comb begin
      rbin_d      = rbin_q + RPTR_W'(rd_fire_s);
      rgray_d     = RPTR_W'(bin2gray(32'(rbin_d)));
      rempty_d    = (rgray_d == wq2_s);
      underflow_d = bus.rinc & rempty_q;
      sticky_d    = sticky_q | underflow_d;
   end

   // Read pointer, empty and underflow state.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_q      <= {RPTR_W{1'b0}};
         rgray_q     <= {RPTR_W{1'b0}};
         rempty_q    <= 1'b1;
         underflow_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         rbin_q      <= rbin_d;
         rgray_q     <= rgray_d;
         rempty_q    <= rempty_d;
         underflow_q <= underflow_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.raddr               = rbin_q[ADDR_SIZE-1:0];
   assign bus.rptr_gray           = rgray_q;
   assign bus.wq2_wptr_gray       = wq2_s;
   assign bus.rempty              = rempty_q;
   assign bus.rd_fire             = rd_fire_s;
   assign bus.rd_underflow        = underflow_q;
   assign bus.rd_underflow_sticky = sticky_q;

endmodule
